// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the ALU opcodes and the signed-overflow rule.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic ops_agree;
    ops_agree = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return ops_agree && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add, sub, and, or with zero and signed-overflow flags.
// Undefined opcodes produce a zero result and no overflow.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctrl)
      CTRL_W'(ALU_ADD): begin
        result   = a + b;
        overflow = signed_ovf(a[DATA_W-1], b[DATA_W-1], result[DATA_W-1], 1'b0);
      end
      CTRL_W'(ALU_SUB): begin
        result   = a - b;
        overflow = signed_ovf(a[DATA_W-1], b[DATA_W-1], result[DATA_W-1], 1'b1);
      end
      CTRL_W'(ALU_AND): result = a & b;
      CTRL_W'(ALU_OR):  result = a | b;
      default:          result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Define ALU_ARB_OVF_STICKY_EN to add the ovf_sticky / ovf_clear sticky overflow flag.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  output logic              ovf_sticky,
  input  logic              ovf_clear
`endif
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_overflow;

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .ctrl     (ctrl_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end
  end

  assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = !rst && (state_q == IDLE) && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant_id ? req1_a : req0_a;
          b_d          = grant_id ? req1_b : req0_b;
          ctrl_d       = grant_id ? req1_ctrl : req0_ctrl;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result;
        zero_d      = alu_zero;
        ovf_d       = alu_overflow;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = result_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;

`ifdef ALU_ARB_OVF_STICKY_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // A completed overflowing response sets the flag even if a clear arrives together.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (rsp_valid_q && rsp_ready && ovf_q) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a behavioural model; sticky checks compile in with ALU_ARB_OVF_STICKY_EN.
module tb_alu_arbiter;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow;
  logic [DW-1:0] rsp_result;
`ifdef ALU_ARB_OVF_STICKY_EN
  logic          ovf_sticky, ovf_clear;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ctrl    (req0_ctrl),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ctrl    (req1_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
`ifdef ALU_ARB_OVF_STICKY_EN
    ,
    .ovf_sticky   (ovf_sticky),
    .ovf_clear    (ovf_clear)
`endif
  );

  // Reference ALU from plain wide signed arithmetic: {overflow, result}.
  function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
    logic signed [65:0] wide;
    logic [63:0]        res;
    logic               ovf;
    wide = '0;
    res  = '0;
    ovf  = 1'b0;
    case (op)
      4'd0: begin
        wide = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        res  = wide[63:0];
        ovf  = (wide > SMAX) || (wide < SMIN);
      end
      4'd1: begin
        wide = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        res  = wide[63:0];
        ovf  = (wide > SMAX) || (wide < SMIN);
      end
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      default: res = '0;
    endcase
    return {ovf, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp_ready  = 1'b0;
`ifdef ALU_ARB_OVF_STICKY_EN
    ovf_clear  = 1'b0;
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_overflow} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_rsp_flags: got %b expected 0000",
                         {rsp_valid, rsp_id, rsp_zero, rsp_overflow});
    end
    checks++;
    if (rsp_result !== '0) begin
      errors++; $display("[TB] FAIL reset_result: got %0h expected 0", rsp_result);
    end
`ifdef ALU_ARB_OVF_STICKY_EN
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_sticky: got %b expected 0", ovf_sticky);
    end
`endif
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_latency();
    req0_valid = 1'b1; req0_a = 64'd10; req0_b = 64'd20; req0_ctrl = 4'b0000;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL add_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_early_valid: got %b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_overflow} !== 4'b1000 || rsp_result !== 64'd30) begin
      errors++; $display("[TB] FAIL add_rsp: got v/id/z/o=%b res=%0d expected 1000 res=30",
                         {rsp_valid, rsp_id, rsp_zero, rsp_overflow}, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL add_handshake: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_tie_after_reset();
    pulse_reset();
    req0_valid = 1'b1; req0_a = 64'd50;   req0_b = 64'd50;   req0_ctrl = 4'b0001;
    req1_valid = 1'b1; req1_a = 64'b1010; req1_b = 64'b1100; req1_ctrl = 4'b0011;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL tie_first_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== '0 || rsp_zero !== 1'b1) begin
      errors++; $display("[TB] FAIL tie_rsp0: got v=%b id=%b res=%0h z=%b expected 1 0 0 1",
                         rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL tie_second_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 64'b1110 || rsp_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL tie_rsp1: got v=%b id=%b res=%0h z=%b expected 1 1 e 0",
                         rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    req0_valid = 1'b1; req0_a = 64'hF0F0; req0_b = 64'h0FF0; req0_ctrl = 4'b0010;
    req1_valid = 1'b1; req1_a = 64'd3;    req1_b = 64'd4;    req1_ctrl = 4'b0000;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL stall_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    tick();
    held = 64'h00F0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_id !== 1'b0 ||
          {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got v=%b res=%0h id=%b rdy=%b expected 1 %0h 0 00",
                           i, rsp_valid, rsp_result, rsp_id, {req0_ready, req1_ready}, held);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL stall_no_accept_in_hs: got %b expected 00", {req0_ready, req1_ready});
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_idle_after: got v=%b rdy1=%b expected 0 1", rsp_valid, req1_ready);
    end
    req1_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_withdraw: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd6; req0_ctrl = 4'b0000;
    #1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== '0 || {req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL rstexec_outputs: got v=%b res=%0h rdy=%b expected 0 0 00",
                         rsp_valid, rsp_result, {req0_ready, req1_ready});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rstexec_no_rsp%0d: got %b expected 0", i, rsp_valid);
      end
    end
    req0_valid = 1'b1; req0_a = 64'hF0; req0_b = 64'h3C; req0_ctrl = 4'b0010;
    req1_valid = 1'b1; req1_a = 64'd1;  req1_b = 64'd1;  req1_ctrl = 4'b0001;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL rstexec_tie: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'h30 || rsp_id !== 1'b0) begin
      errors++; $display("[TB] FAIL rstexec_rsp: got v=%b res=%0h id=%b expected 1 30 0",
                         rsp_valid, rsp_result, rsp_id);
    end
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
`ifdef ALU_ARB_OVF_STICKY_EN
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_init: got %b expected 0", ovf_sticky);
    end
`endif
    for (int n = 0; n < 2; n++) begin
      req0_valid = 1'b1; req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_ctrl = 4'b0000;
      #1;
      tick();
      req0_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 64'h8000_0000_0000_0000 ||
          rsp_overflow !== 1'b1 || rsp_zero !== 1'b0) begin
        errors++; $display("[TB] FAIL ovf_rsp%0d: got v=%b res=%0h o=%b z=%b expected 1 8000000000000000 1 0",
                           n, rsp_valid, rsp_result, rsp_overflow, rsp_zero);
      end
`ifdef ALU_ARB_OVF_STICKY_EN
      if (n == 0) begin
        checks++;
        if (ovf_sticky !== 1'b0) begin
          errors++; $display("[TB] FAIL sticky_before_hs: got %b expected 0", ovf_sticky);
        end
      end else begin
        ovf_clear = 1'b1;
      end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`ifdef ALU_ARB_OVF_STICKY_EN
      ovf_clear = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b1) begin
        errors++; $display("[TB] FAIL sticky_set%0d: got %b expected 1", n, ovf_sticky);
      end
`endif
    end
`ifdef ALU_ARB_OVF_STICKY_EN
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_clear: got %b expected 0", ovf_sticky);
    end
`endif
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic          pend[2];
    logic [63:0]   pa[2];
    logic [63:0]   pb[2];
    logic [3:0]    pc[2];
    int            last;
    int            g;
    int            stall;
    logic [64:0]   exp;
    pulse_reset();
    last = 1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int op = 0; op < 40; op++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          pa[r] = pick_operand();
          pb[r] = ($urandom_range(0, 7) == 0) ? pa[r] : pick_operand();
          pc[r] = 4'($urandom_range(0, 3));
        end
      end
      if (!pend[0] && !pend[1]) begin
        g = $urandom_range(0, 1);
        pend[g] = 1'b1;
        pa[g] = pick_operand();
        pb[g] = pick_operand();
        pc[g] = 4'($urandom_range(0, 3));
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_ctrl = pc[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_ctrl = pc[1];
      if (pend[0] && pend[1]) g = 1 - last;
      else                    g = pend[1] ? 1 : 0;
      exp = ref_alu(pa[g], pb[g], pc[g]);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL rnd_grant op%0d: got r1r0=%b expected grant to %0d",
                           op, {req1_ready, req0_ready}, g);
      end
      tick();
      last = g;
      pend[g] = 1'b0;
      if (g == 1) req1_valid = 1'b0;
      else        req0_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("[TB] FAIL rnd_exec op%0d: got v=%b rdy=%b expected 0 00",
                           op, rsp_valid, {req0_ready, req1_ready});
      end
      tick();
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== g[0] || rsp_result !== exp[63:0] ||
            rsp_overflow !== exp[64] || rsp_zero !== (exp[63:0] == 64'd0) ||
            {req0_ready, req1_ready} !== 2'b00) begin
          errors++; $display("[TB] FAIL rnd_rsp op%0d: got v=%b id=%b res=%0h o=%b z=%b expected 1 %0d %0h %b %b",
                             op, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero,
                             g, exp[63:0], exp[64], (exp[63:0] == 64'd0));
        end
        if (s < stall) tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rnd_handshake op%0d: got %b expected 0", op, rsp_valid);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_add_latency();
    test_tie_after_reset();
    test_stall();
    test_reset_exec();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
